risc16_mem: RTL

RISC16_MEM -- requirements
Module: risc16_mem

---
 rtl/risc16_mem_if.sv | 25 ++
 rtl/risc16_mem.sv | 121 ++++++++++++
 2 files changed

// File: rtl/risc16_mem_if.sv
// Bus bundle for risc16_mem: instruction port, data port and output-queue handshake.
// master = CPU/consumer side, slave = memory side.
interface risc16_mem_if;
    logic [15:0] i_addr;
    logic        i_oe;
    logic [15:0] i_din;
    logic [15:0] d_addr;
    logic        d_oe;
    logic [15:0] d_din;
    logic [15:0] d_dout;
    logic [1:0]  d_we;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output i_addr, i_oe, d_addr, d_oe, d_dout, d_we, out_ready,
        input  i_din, d_din, out_data, out_valid
    );

    modport slave (
        input  i_addr, i_oe, d_addr, d_oe, d_dout, d_we, out_ready,
        output i_din, d_din, out_data, out_valid
    );
endinterface

// File: rtl/risc16_mem.sv
// Dual-read-port 16-bit big-endian RAM for a RISC16 core with per-byte writes.
// Define RISC16_MEM_MMIO_EN to map 0xFFF0-0xFFFF to cycle counter, output queue and status.
module risc16_mem #(
    parameter int MEM_AWIDTH = 12,
    parameter int OUTQ_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    risc16_mem_if.slave bus
);
    localparam int WORDS = 2 ** MEM_AWIDTH;

    logic [15:0]           mem_q [WORDS];
    logic [MEM_AWIDTH-1:0] i_idx;
    logic [MEM_AWIDTH-1:0] d_idx;
    logic                  mmio_sel;
    logic [15:0]           mmio_rdata;
    logic [1:0]            ram_we;

    assign i_idx  = bus.i_addr[MEM_AWIDTH:1];
    assign d_idx  = bus.d_addr[MEM_AWIDTH:1];
    assign ram_we = (rst || mmio_sel) ? 2'b00 : bus.d_we;

    // NOTE: the RAM array is deliberately left out of reset; program contents survive rst.
    always_ff @(posedge clk) begin
        if (ram_we[0]) mem_q[d_idx][15:8] <= bus.d_dout[15:8];
        if (ram_we[1]) mem_q[d_idx][7:0]  <= bus.d_dout[7:0];
    end

    // Combinational reads see the array before this edge's write lands.
    assign bus.i_din = bus.i_oe ? mem_q[i_idx] : 16'h0000;
    assign bus.d_din = !bus.d_oe ? 16'h0000 : (mmio_sel ? mmio_rdata : mem_q[d_idx]);

`ifdef RISC16_MEM_MMIO_EN
    localparam int PW = $clog2(OUTQ_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(OUTQ_DEPTH);

    logic [15:0]   cycle_q, cycle_d;
    logic [7:0]    outq_q [OUTQ_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          empty, full, pop;
    logic          push_req, push_ok, ovf_clr;
    logic [7:0]    push_byte;
    logic          unused_addr;

    assign mmio_sel  = (bus.d_addr[15:4] == 12'hFFF);
    assign empty     = (count_q == '0);
    assign full      = (count_q == DEPTH_C);
    assign pop       = !empty && bus.out_ready;
    assign push_req  = mmio_sel && (bus.d_addr[3:1] == 3'd1) && (bus.d_we != 2'b00);
    assign ovf_clr   = mmio_sel && (bus.d_addr[3:1] == 3'd2) && (bus.d_we != 2'b00);
    assign push_ok   = push_req && (!full || pop);
    assign push_byte = bus.d_we[1] ? bus.d_dout[7:0] : bus.d_dout[15:8];

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path infers a latch.
        cycle_d  = cycle_q + 16'd1;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
        if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // A dropped push outranks a same-cycle clear.
        if (push_req && !push_ok) ovf_d = 1'b1;
        else if (ovf_clr)         ovf_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every register samples pre-edge values regardless of order.
        if (rst) begin
            cycle_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            cycle_q  <= cycle_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !rst) outq_q[wr_ptr_q] <= push_byte;
    end

    always_comb begin
        mmio_rdata = 16'h0000;
        case (bus.d_addr[3:1])
            3'd0:    mmio_rdata = cycle_q;
            3'd2:    mmio_rdata = {8'h00, ovf_q, 1'b0, empty, full, 4'(count_q)};
            default: mmio_rdata = 16'h0000;
        endcase
    end

    assign bus.out_valid = !empty;
    assign bus.out_data  = empty ? 8'h00 : outq_q[rd_ptr_q];
    assign unused_addr   = ^{bus.i_addr[15:MEM_AWIDTH+1], bus.i_addr[0], bus.d_addr[0]};
`else
    logic unused_mmio;

    assign mmio_sel      = 1'b0;
    assign mmio_rdata    = 16'h0000;
    assign bus.out_valid = 1'b0;
    assign bus.out_data  = 8'h00;
    assign unused_mmio   = ^{bus.i_addr[15:MEM_AWIDTH+1], bus.i_addr[0],
                             bus.d_addr[15:MEM_AWIDTH+1], bus.d_addr[0], bus.out_ready};
`endif
endmodule
